// File: rtl/game_round_controller.sv
// Basketball round controller: debounced hoop sensing, timed or race-to-score rounds, leaderboard strobe.
// Latency: make 2+DEBOUNCE_CYCLES+1 cycles after a hoop edge, score/time update next edge; no backpressure.
module game_round_controller #(
   parameter int TICK_CYCLES     = 50000000,
   parameter int START_TIME      = 30,
   parameter int END_SCORE       = 10,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       game_mode,
   input  logic [2:0] hoop_sw,
   output logic [1:0] state,
   output logic [7:0] score,
   output logic [7:0] time_val,
   output logic       make,
   output logic       game_over,
   output logic       lb_we,
   output logic       lb_mode,
   output logic [7:0] lb_value
);

   localparam int TW = $clog2(TICK_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]    START_V   = 8'(START_TIME);
   localparam logic [7:0]    END_V     = 8'(END_SCORE);
   localparam logic [7:0]    MAX_V     = 8'd99;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          st;
   logic [2:0]      sync1, sync2;
   logic            hoop_any;
   logic [DW-1:0]   deb_cnt;
   logic            deb_lvl, deb_rise;
   logic [TW-1:0]   tick_cnt;
   logic            mode;
   logic            tick, round_end;
   logic [7:0]      score_nx, time_nx;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= hoop_sw;
         sync2 <= sync1;
      end
   end

   assign hoop_any = |sync2;

   // Any sample agreeing with the current level restarts the stability count.
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_cnt  <= '0;
         deb_lvl  <= 1'b0;
         deb_rise <= 1'b0;
      end else begin
         deb_rise <= 1'b0;
         if (hoop_any != deb_lvl) begin
            if (deb_cnt == DEB_LAST) begin
               deb_lvl  <= hoop_any;
               deb_cnt  <= '0;
               deb_rise <= hoop_any;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Gated by the current state so a basket can never be reported outside RUN.
   assign make = deb_rise && (st == RUN);

   always_comb begin
      tick     = (tick_cnt == TICK_LAST);
      score_nx = (make && score < MAX_V) ? score + 8'd1 : score;
      time_nx  = time_val;
      if (tick) begin
         if (!mode) time_nx = (time_val != 8'd0) ? time_val - 8'd1 : 8'd0;
         else       time_nx = (time_val < MAX_V) ? time_val + 8'd1 : MAX_V;
      end
      if (!mode) round_end = tick && (time_nx == 8'd0);
      else       round_end = (make && score_nx == END_V) || (tick && time_nx == MAX_V);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st       <= IDLE;
         score    <= '0;
         time_val <= '0;
         tick_cnt <= '0;
         mode     <= 1'b0;
         lb_we    <= 1'b0;
         lb_mode  <= 1'b0;
         lb_value <= '0;
      end else begin
         lb_we <= 1'b0;
         case (st)
            IDLE, DONE: begin
               if (start) begin
                  st       <= RUN;
                  mode     <= game_mode;
                  score    <= '0;
                  tick_cnt <= '0;
                  time_val <= game_mode ? 8'd0 : START_V;
               end
            end
            RUN: begin
               tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
               score    <= score_nx;
               time_val <= time_nx;
               if (round_end) begin
                  st       <= DONE;
                  lb_we    <= 1'b1;
                  lb_mode  <= mode;
                  lb_value <= mode ? time_nx : score_nx;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign state     = st;
   assign game_over = (st == DONE);

endmodule

// File: tb/tb_game_round_controller.sv
// Directed and random stimulus against a game-level reference model of the round controller.
module tb_game_round_controller;

   logic       clock = 1'b0;
   logic       reset, start, game_mode;
   logic [2:0] hoop_sw;
   logic [1:0] state;
   logic [7:0] score, time_val, lb_value;
   logic       make, game_over, lb_we, lb_mode;

   game_round_controller #(
      .TICK_CYCLES(10), .START_TIME(5), .END_SCORE(3), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .game_mode(game_mode),
      .hoop_sw(hoop_sw), .state(state), .score(score), .time_val(time_val),
      .make(make), .game_over(game_over), .lb_we(lb_we), .lb_mode(lb_mode),
      .lb_value(lb_value)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int n_make = 0;
   int n_lbwe = 0;

   // Reference model: hoop history plus round-level bookkeeping.
   bit h [8192];
   int e = 0;
   int last_acc = 0;
   bit lvl = 0;
   bit m_rise = 0;
   int m_state = 0, m_score = 0, m_time = 0, m_mode = 0, m_run = 0;
   int m_lbwe = 0, m_lbmode = 0, m_lbval = 0;

   function automatic bit any_at(int k);
      return (k >= 2) ? h[k-2] : 1'b0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit mk, tk, ok, fin;
      mk = m_rise && (m_state == 1);
      h[e] = |hoop_sw;
      if (reset) begin
         h[e] = 0;
         if (e > 0) h[e-1] = 0;
         lvl = 0; last_acc = e; m_rise = 0;
         m_state = 0; m_score = 0; m_time = 0; m_mode = 0; m_run = 0;
         m_lbwe = 0; m_lbmode = 0; m_lbval = 0;
      end else begin
         // A new level needs four consecutive differing synchronized samples since the last change.
         ok = 1;
         for (int j = 0; j < 4; j++)
            if (e - j <= last_acc || any_at(e - j) == lvl) ok = 0;
         m_rise = 0;
         if (ok) begin
            lvl = !lvl; last_acc = e; m_rise = lvl;
         end
         m_lbwe = 0;
         if (m_state != 1) begin
            if (start) begin
               m_state = 1; m_mode = game_mode; m_score = 0; m_run = 0;
               m_time = game_mode ? 0 : 5;
            end
         end else begin
            tk = (m_run % 10) == 9;
            m_run++;
            if (mk && m_score < 99) m_score++;
            if (tk) m_time = m_mode ? ((m_time < 99) ? m_time + 1 : 99) : ((m_time > 0) ? m_time - 1 : 0);
            fin = m_mode ? ((mk && m_score == 3) || (tk && m_time == 99)) : (tk && m_time == 0);
            if (fin) begin
               m_state = 2; m_lbwe = 1; m_lbmode = m_mode;
               m_lbval = m_mode ? m_time : m_score;
            end
         end
      end
      e++;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      chk("state", state, m_state);
      chk("score", score, m_score);
      chk("time_val", time_val, m_time);
      chk("make", make, (m_rise && m_state == 1) ? 1 : 0);
      chk("game_over", game_over, (m_state == 2) ? 1 : 0);
      chk("lb_we", lb_we, m_lbwe);
      chk("lb_mode", lb_mode, m_lbmode);
      chk("lb_value", lb_value, m_lbval);
      if (make === 1'b1) n_make++;
      if (lb_we === 1'b1) n_lbwe++;
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic press(int hi, int lo);
      hoop_sw = 3'($urandom_range(1, 7));
      run(hi);
      hoop_sw = 3'b000;
      run(lo);
   endtask

   task automatic begin_round(bit md);
      game_mode = md; start = 1'b1;
      step();
      start = 1'b0; game_mode = $urandom_range(0, 1);
      n_make = 0; n_lbwe = 0;
   endtask

   task automatic wait_done(int budget);
      int c = 0;
      while (game_over !== 1'b1 && c < budget) begin
         step();
         c++;
      end
      chk("done_reached", game_over, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; game_mode = 1'b0; hoop_sw = 3'b000;
      run(3);
      chk("rst_state", state, 0);
      chk("rst_outputs", {score, time_val, lb_value, make, lb_we, lb_mode, game_over}, 0);
      reset = 1'b0;
      run(2);

      // Presses while idle are ignored.
      n_make = 0;
      press(8, 8);
      chk("idle_press_make", n_make, 0);
      chk("idle_score", score, 0);

      // Timed round with two baskets.
      begin_round(1'b0);
      press(8, 8);
      press(8, 8);
      wait_done(100);
      run(3);
      chk("m0_makes", n_make, 2);
      chk("m0_lbwe_count", n_lbwe, 1);
      chk("m0_lb_value", lb_value, 2);
      chk("m0_lb_mode", lb_mode, 0);
      chk("m0_time_end", time_val, 0);

      // Presses in DONE are ignored.
      n_make = 0;
      press(8, 8);
      chk("done_press_make", n_make, 0);
      chk("done_score", score, 2);

      // Race round; game_mode is scrambled after the start cycle.
      begin_round(1'b1);
      press(8, 8);
      press(8, 8);
      press(8, 8);
      wait_done(60);
      run(2);
      chk("m1_makes", n_make, 3);
      chk("m1_score", score, 3);
      chk("m1_lb_mode", lb_mode, 1);
      chk("m1_lbwe_count", n_lbwe, 1);

      // Glitch and bounce rejection.
      begin_round(1'b0);
      hoop_sw = 3'b010; run(3);
      hoop_sw = 3'b000; run(6);
      chk("glitch_make", n_make, 0);
      hoop_sw = 3'b100; run(1);
      hoop_sw = 3'b000; run(1);
      hoop_sw = 3'b100; run(10);
      hoop_sw = 3'b000; run(6);
      chk("bounce_make", n_make, 1);
      wait_done(60);
      chk("bounce_lb_value", lb_value, 1);

      // Basket landing on the final tick.
      begin_round(1'b0);
      run(43);
      hoop_sw = 3'b001;
      wait_done(30);
      hoop_sw = 3'b000;
      run(3);
      chk("final_tick_makes", n_make, 1);
      chk("final_tick_score", score, 1);
      chk("final_tick_lb_value", lb_value, 1);
      chk("final_tick_lbwe", n_lbwe, 1);

      // Reset beats start mid-round.
      begin_round(1'b1);
      run(15);
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      chk("abort_state", state, 0);
      chk("abort_outputs", {score, time_val, lb_value, lb_mode, game_over}, 0);
      run(3);
      chk("abort_lbwe", n_lbwe, 0);
      chk("abort_stays_idle", state, 0);

      // Fresh round with start pulses that must not restart it.
      begin_round(1'b0);
      chk("fresh_time", time_val, 5);
      run(12);
      start = 1'b1; step(); start = 1'b0;
      chk("start_ignored_time", time_val, 4);
      run(10);
      start = 1'b1; run(3); start = 1'b0;
      chk("start_ignored_state", state, 1);
      wait_done(60);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 39) == 0);
         game_mode = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) hoop_sw = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; start = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_round_controller.md
GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000: clock cycles per game-time tick (1 s at 50 MHz).
REQ-002 SHALL have parameter START_TIME, default 30: mode-0 countdown start value, in ticks.
REQ-003 SHALL have parameter END_SCORE, default 10: mode-1 target score.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles needed before a hoop input change is accepted.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clock, input, 1: system clock.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: start request, sampled each cycle.
REQ-009 SHALL have port game_mode, input, 1: 0 = timed countdown, 1 = race to END_SCORE.
REQ-010 SHALL have port hoop_sw, input, 3: raw asynchronous hoop sensor switches.
REQ-011 SHALL have port state, output, 2: IDLE=0, RUN=1, DONE=2.
REQ-012 SHALL have port score, output, 8: baskets this round.
REQ-013 SHALL have port time_val, output, 8: remaining ticks in mode 0; elapsed ticks in mode 1.
REQ-014 SHALL have port make, output, 1: one-cycle pulse per accepted basket.
REQ-015 SHALL have port game_over, output, 1: high while in DONE.
REQ-016 SHALL have port lb_we, output, 1: one-cycle leaderboard write strobe.
REQ-017 SHALL have port lb_mode, output, 1: latched mode that accompanies lb_we.
REQ-018 SHALL have port lb_value, output, 8: value written (score in mode 0, elapsed time in mode 1).

Function
REQ-019 SHALL pass each hoop_sw bit through a 2-flop synchronizer, then OR the three bits into hoop_any.
REQ-020 SHALL accept a new debounced level only after hoop_any has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-021 SHALL assert make for exactly one cycle on a debounced 0->1 transition, and only while state=RUN.
REQ-022 IDLE: score, time_val, tick counter held at 0; start=1 -> RUN next cycle, latching game_mode into the mode register, loading time_val with START_TIME (mode 0) or 0 (mode 1), clearing score and the tick counter.
REQ-023 RUN: tick counter counts 0..TICK_CYCLES-1 and wraps; a tick fires on the wrap cycle; start is ignored.
REQ-024 RUN: on each tick, mode 0 decrements time_val and mode 1 increments time_val, saturating at 99.
REQ-025 RUN: on each make, score increments, saturating at 99.
REQ-026 End condition, mode 0: a tick that takes time_val to 0 -> DONE.
REQ-027 End condition, mode 1: a make that takes score to END_SCORE -> DONE; time_val reaching 99 also -> DONE.
REQ-028 Simultaneous make and final tick: both updates SHALL apply in that cycle, then -> DONE.
REQ-029 Entering DONE: lb_we=1 for exactly the first DONE cycle, with lb_value and lb_mode valid in the same cycle; score and time_val frozen.
REQ-030 DONE: start=1 -> RUN with re-initialisation per REQ-022 and a newly latched game_mode.
REQ-031 game_mode changes outside the start cycle SHALL have no effect on the round in progress.
REQ-032 make SHALL never be asserted in IDLE or DONE, and lb_we SHALL never be asserted outside the DONE entry cycle.

Reset
REQ-033 On reset=1 at a clock edge: state=IDLE; score, time_val, lb_value, tick counter, debounce counter and debounced level =0; make, lb_we, lb_mode, game_over =0.
REQ-034 Reset mid-RUN or in DONE SHALL abort the round with no lb_we pulse; reset SHALL take priority over start in the same cycle.

Verification (bench params: TICK_CYCLES=10, START_TIME=5, END_SCORE=3, DEBOUNCE_CYCLES=4)
REQ-035 Mode 0, start, two clean presses, no further input -> make x2, time_val 5,4,..,0 every 10 cycles, DONE at cycle ~50, lb_we=1 once with lb_value=2, lb_mode=0.
REQ-036 Mode 1, three clean presses -> DONE on the third make, lb_value equals elapsed ticks, score=3, lb_mode=1.
REQ-037 hoop_sw glitch of 3 cycles, then a bounce 1-0-1 followed by a stable high -> no make for the glitch; exactly one make once the stable high passes debounce.
REQ-038 Mode 0, press timed so make lands on the final tick -> score includes the basket, single lb_we.
REQ-039 reset asserted mid-RUN with start=1 in the same cycle -> IDLE, outputs 0, no lb_we; start after release -> fresh round.
REQ-040 Presses in IDLE and DONE, and start pulses during RUN -> no make, no score change, no restart.
